// File: rtl/fifo_unpacker_pkg.sv
// Shared types and helpers for the FIFO word-to-beat unpacker.
package fifo_unpacker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_e;

    // Counter width max(1, $clog2(n)); keeps a 1-bit counter when RATIO == 1.
    function automatic int unsigned beat_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops wide words from a Fifo and serializes each into little-endian
// narrow beats on a valid/ready stream; supports show-ahead and registered reads.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH_BYTES = 4,
    parameter int unsigned OUT_BYTES        = 1,
    parameter int unsigned SHOWAHEAD        = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fifo_empty_in,
    input  logic [FIFO_WIDTH_BYTES*8-1:0] fifo_data_in,
    output logic                          fifo_read_out,
    output logic                          out_valid_out,
    output logic [OUT_BYTES*8-1:0]        out_data_out,
    output logic                          out_last_out,
    input  logic                          out_ready_in,
    input  logic                          clear_in,
    input  logic                          debugen_in
);

    localparam int unsigned RATIO = FIFO_WIDTH_BYTES / OUT_BYTES;
    localparam int unsigned IN_W  = FIFO_WIDTH_BYTES * 8;
    localparam int unsigned OUT_W = OUT_BYTES * 8;
    localparam int unsigned BW    = beat_width(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [IN_W-1:0] word_q,  word_d;

    logic valid, at_last, accept, done, pop;

    assign valid   = (state_q == SEND);
    assign at_last = (beat_q == LAST_BEAT);
    // A beat shown during clear is never treated as consumed.
    assign accept  = valid && out_ready_in && !clear_in;
    assign done    = accept && at_last;
    assign pop     = (state_q == IDLE || done) && !fifo_empty_in && !clear_in && !reset;

    assign fifo_read_out = pop;
    assign out_valid_out = valid;
    assign out_last_out  = valid && at_last;
    assign out_data_out  = valid ? word_q[int'(beat_q)*OUT_W +: OUT_W] : '0;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        if (clear_in) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (pop) begin
            beat_d = '0;
            if (SHOWAHEAD != 0) begin
                word_d  = fifo_data_in;
                state_d = SEND;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    word_d  = fifo_data_in;
                    beat_d  = '0;
                    state_d = SEND;
                end
                SEND: begin
                    if (done) begin
                        state_d = IDLE;
                    end else if (accept) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && debugen_in && accept) begin
            $write("%m: beat %x data %x last %x\n", beat_q, out_data_out, out_last_out);
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Table-driven bench: three unpacker configurations, each fed by a small FIFO model.
module tb_fifo_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic dbg = 1'b0;

    // Instance 0: W=4 O=1 SHOWAHEAD=1
    logic        a_rst = 1'b1, a_rdy = 1'b0, a_clr = 1'b0;
    logic [31:0] a_mem [16];
    logic [4:0]  a_wr = '0, a_rd = '0;
    logic        a_empty, a_read, a_v, a_l;
    logic [31:0] a_fd;
    logic [7:0]  a_do;
    int          a_reads = 0;
    assign a_empty = (a_wr == a_rd);
    assign a_fd    = a_mem[a_rd[3:0]];
    always @(posedge clk) if (a_read) begin a_rd <= a_rd + 1'b1; a_reads <= a_reads + 1; end

    // Instance 1: W=4 O=1 SHOWAHEAD=0 (registered read data)
    logic        b_rst = 1'b1, b_rdy = 1'b0, b_clr = 1'b0;
    logic [31:0] b_mem [16];
    logic [4:0]  b_wr = '0, b_rd = '0;
    logic        b_empty, b_read, b_v, b_l;
    logic [31:0] b_fd = '0;
    logic [7:0]  b_do;
    int          b_reads = 0;
    assign b_empty = (b_wr == b_rd);
    always @(posedge clk) if (b_read) begin
        b_fd    <= b_mem[b_rd[3:0]];
        b_rd    <= b_rd + 1'b1;
        b_reads <= b_reads + 1;
    end

    // Instance 2: W=8 O=2 SHOWAHEAD=1
    logic        c_rst = 1'b1, c_rdy = 1'b0, c_clr = 1'b0;
    logic [63:0] c_mem [16];
    logic [4:0]  c_wr = '0, c_rd = '0;
    logic        c_empty, c_read, c_v, c_l;
    logic [63:0] c_fd;
    logic [15:0] c_do;
    int          c_reads = 0;
    assign c_empty = (c_wr == c_rd);
    assign c_fd    = c_mem[c_rd[3:0]];
    always @(posedge clk) if (c_read) begin c_rd <= c_rd + 1'b1; c_reads <= c_reads + 1; end

    fifo_unpacker #(.FIFO_WIDTH_BYTES(4), .OUT_BYTES(1), .SHOWAHEAD(1)) u_a (
        .clk(clk), .reset(a_rst), .fifo_empty_in(a_empty), .fifo_data_in(a_fd),
        .fifo_read_out(a_read), .out_valid_out(a_v), .out_data_out(a_do), .out_last_out(a_l),
        .out_ready_in(a_rdy), .clear_in(a_clr), .debugen_in(dbg));

    fifo_unpacker #(.FIFO_WIDTH_BYTES(4), .OUT_BYTES(1), .SHOWAHEAD(0)) u_b (
        .clk(clk), .reset(b_rst), .fifo_empty_in(b_empty), .fifo_data_in(b_fd),
        .fifo_read_out(b_read), .out_valid_out(b_v), .out_data_out(b_do), .out_last_out(b_l),
        .out_ready_in(b_rdy), .clear_in(b_clr), .debugen_in(dbg));

    fifo_unpacker #(.FIFO_WIDTH_BYTES(8), .OUT_BYTES(2), .SHOWAHEAD(1)) u_c (
        .clk(clk), .reset(c_rst), .fifo_empty_in(c_empty), .fifo_data_in(c_fd),
        .fifo_read_out(c_read), .out_valid_out(c_v), .out_data_out(c_do), .out_last_out(c_l),
        .out_ready_in(c_rdy), .clear_in(c_clr), .debugen_in(dbg));

    typedef struct {
        int unsigned inst;
        bit          push;
        logic [63:0] pdata;
        bit          ready, clear, rst, chk_out;
        bit          exp_read, exp_valid;
        logic [15:0] exp_data;
        bit          exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t V(int unsigned inst, bit push, logic [63:0] pdata, bit ready,
                               bit clear, bit rst, bit chk_out, bit rd, bit vld,
                               logic [15:0] data, bit last);
        vec_t v;
        v.inst = inst; v.push = push; v.pdata = pdata; v.ready = ready; v.clear = clear;
        v.rst = rst; v.chk_out = chk_out; v.exp_read = rd; v.exp_valid = vld;
        v.exp_data = data; v.exp_last = last;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int unsigned inst, input logic [63:0] d);
        case (inst)
            0: begin a_mem[a_wr[3:0]] = d[31:0]; a_wr = a_wr + 1'b1; end
            1: begin b_mem[b_wr[3:0]] = d[31:0]; b_wr = b_wr + 1'b1; end
            default: begin c_mem[c_wr[3:0]] = d; c_wr = c_wr + 1'b1; end
        endcase
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic        rd, vl, la;
        logic [15:0] dd;
        @(negedge clk);
        case (v.inst)
            0: begin a_rst = v.rst; a_rdy = v.ready; a_clr = v.clear; end
            1: begin b_rst = v.rst; b_rdy = v.ready; b_clr = v.clear; end
            default: begin c_rst = v.rst; c_rdy = v.ready; c_clr = v.clear; end
        endcase
        if (v.push) push(v.inst, v.pdata);
        #1;
        case (v.inst)
            0: begin rd = a_read; vl = a_v; la = a_l; dd = {8'h00, a_do}; end
            1: begin rd = b_read; vl = b_v; la = b_l; dd = {8'h00, b_do}; end
            default: begin rd = c_read; vl = c_v; la = c_l; dd = c_do; end
        endcase
        chk({tag, " read"}, 64'(rd), 64'(v.exp_read));
        if (v.chk_out) begin
            chk({tag, " valid"}, 64'(vl), 64'(v.exp_valid));
            chk({tag, " data"},  64'(dd), 64'(v.exp_data));
            chk({tag, " last"},  64'(la), 64'(v.exp_last));
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Reset state of every configuration.
        for (int unsigned i = 0; i < 3; i++) tbl.push_back(V(i, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0, 0));

        // SHOWAHEAD=1: two words back to back, no bubble.
        tbl.push_back(V(0, 1, 64'h44332211, 1, 0, 0, 1, 1, 0, 16'h00, 0));
        tbl.push_back(V(0, 1, 64'h88776655, 1, 0, 0, 1, 0, 1, 16'h11, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h22, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h33, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 1, 1, 16'h44, 1));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h55, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h66, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h77, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h88, 1));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0));
        // Backpressure on 0xDDCCBBAA.
        tbl.push_back(V(0, 1, 64'hDDCCBBAA, 1, 0, 0, 1, 1, 0, 16'h00, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'hAA, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hBB, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hBB, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'hBB, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hCC, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hCC, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'hCC, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hDD, 1));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hDD, 1));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'hDD, 1));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0));
        // Clear while beat 0x22 is shown and the next word is waiting.
        tbl.push_back(V(0, 1, 64'h44332211, 1, 0, 0, 1, 1, 0, 16'h00, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h11, 0));
        tbl.push_back(V(0, 1, 64'h88776655, 1, 1, 0, 1, 0, 1, 16'h22, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 1, 0, 16'h00, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h55, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h66, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h77, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h88, 1));
        tbl.push_back(V(0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0));

        // SHOWAHEAD=0: one FETCH cycle ahead of each word.
        tbl.push_back(V(1, 1, 64'h44332211, 1, 0, 0, 1, 1, 0, 16'h00, 0));
        tbl.push_back(V(1, 1, 64'h88776655, 1, 0, 0, 1, 0, 0, 16'h00, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h11, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h22, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h33, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 1, 1, 16'h44, 1));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h55, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h66, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h77, 0));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h88, 1));
        tbl.push_back(V(1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0));

        // W=8 O=2: empty FIFO, then reset in the middle of a word.
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0));
        tbl.push_back(V(2, 1, 64'h8877665544332211, 1, 0, 0, 1, 1, 0, 16'h0000, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'h2211, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'h4433, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0));
        tbl.push_back(V(2, 1, 64'hDDDDCCCCBBBBAAAA, 1, 0, 0, 1, 1, 0, 16'h0000, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'hAAAA, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'hBBBB, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'hCCCC, 0));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 1, 16'hDDDD, 1));
        tbl.push_back(V(2, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Hand sequence: clear during FETCH discards the word being returned.
        apply(V(1, 1, 64'hA1B2C3D4, 1, 0, 0, 1, 1, 0, 16'h00, 0), "fetchclr pop");
        apply(V(1, 1, 64'h0F0E0D0C, 1, 1, 0, 1, 0, 0, 16'h00, 0), "fetchclr clear");
        apply(V(1, 0, 0, 1, 0, 0, 1, 1, 0, 16'h00, 0), "fetchclr repop");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0), "fetchclr fetch");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0C, 0), "fetchclr b0");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0D, 0), "fetchclr b1");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0E, 0), "fetchclr b2");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0F, 1), "fetchclr b3");
        apply(V(1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h00, 0), "fetchclr idle");

        @(negedge clk);
        chk("a read count", 64'(a_reads), 64'd5);
        chk("b read count", 64'(b_reads), 64'd4);
        chk("c read count", 64'(c_reads), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
